// File: rtl/fifo_wrr_sched.sv
// ---------------------------------------------------------------------------
// fifo_wrr_sched
//
// Frame-level scheduler for the axis_mux that drains the per-priority ingress
// FIFOs onto the single TX stream. One whole frame is granted at a time. The
// grant is released only by the tlast handshake on the mux output. Two
// selection modes are supported:
//   - strict priority: the lowest-index queue with tvalid set wins
//   - weighted round-robin: each queue may send cfg_weight[i] frames per
//     round. Credits are reloaded when no valid queue has credit left.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous, active-low reset
//   s_axis_tvalid  per-queue FIFO output tvalid (mux inputs)
//   m_axis_tvalid  mux output tvalid
//   m_axis_tready  mux output tready
//   m_axis_tlast   mux output tlast
//   cfg_strict     1 = strict priority, 0 = WRR (sampled in IDLE only)
//   cfg_weight     per-queue frames-per-round, queue i at [i*W +: W]
//   sel            registered mux select
//   en             registered mux enable
//   round_count    number of WRR credit reloads (wraps)
// ---------------------------------------------------------------------------
module fifo_wrr_sched #(
  parameter int N_FIFO          = 3,
  parameter int SEL_WIDTH       = $clog2(N_FIFO),
  parameter int WEIGHT_WIDTH    = 8,
  parameter int ROUND_CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_FIFO-1:0]              s_axis_tvalid,
  input  logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  input  logic                           m_axis_tlast,
  input  logic                           cfg_strict,
  input  logic [N_FIFO*WEIGHT_WIDTH-1:0] cfg_weight,
  output logic [SEL_WIDTH-1:0]           sel,
  output logic                           en,
  output logic [ROUND_CNT_WIDTH-1:0]     round_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [SEL_WIDTH-1:0]        sel_q, sel_d;
  logic                        en_q, en_d;
  logic                        strict_q, strict_d;   // mode the current grant was made in
  logic [SEL_WIDTH-1:0]        ptr_q, ptr_d;
  logic [ROUND_CNT_WIDTH-1:0]  round_q, round_d;
  logic [WEIGHT_WIDTH-1:0]     credit_q [N_FIFO];
  logic [WEIGHT_WIDTH-1:0]     credit_d [N_FIFO];

  // Per-queue reload value (a zero weight counts as one frame) and credit flag.
  logic [WEIGHT_WIDTH-1:0]     reload_val [N_FIFO];
  logic [N_FIFO-1:0]           has_credit;

  for (genvar gi = 0; gi < N_FIFO; gi++) begin : g_queue
    assign reload_val[gi] = (cfg_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                          ? WEIGHT_WIDTH'(1)
                          : cfg_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign has_credit[gi] = (credit_q[gi] != '0);
  end

  logic                        any_valid;
  logic                        need_reload;
  logic [N_FIFO-1:0]           eligible;
  logic [SEL_WIDTH-1:0]        pick;
  logic                        found;
  int                          start_idx;
  int                          idx;
  logic                        frame_end;

  assign any_valid = |s_axis_tvalid;
  assign frame_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // In WRR, if every valid queue is out of credit the reload happens in the
  // same decision cycle. All reloaded credits are nonzero, so every valid
  // queue is then eligible.
  assign need_reload = ~cfg_strict & ~|(s_axis_tvalid & has_credit);

  always_comb begin
    eligible = s_axis_tvalid;
    if (!cfg_strict && !need_reload) begin
      eligible = s_axis_tvalid & has_credit;
    end
  end

  // Circular first-match search. Strict mode always starts at queue 0.
  always_comb begin
    pick      = '0;
    found     = 1'b0;
    idx       = 0;
    start_idx = cfg_strict ? 0 : int'(ptr_q);
    for (int k = 0; k < N_FIFO; k++) begin
      idx = (start_idx + k) % N_FIFO;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = SEL_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    en_d     = 1'b0;
    strict_d = strict_q;
    ptr_d    = ptr_q;
    round_d  = round_q;
    credit_d = credit_q;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d  = ST_ACTIVE;
          sel_d    = pick;
          en_d     = 1'b1;
          strict_d = cfg_strict;
          if (need_reload) begin
            credit_d = reload_val;
            round_d  = round_q + ROUND_CNT_WIDTH'(1);
          end
        end
      end

      ST_ACTIVE: begin
        en_d = 1'b1;
        // The grant is held until the tlast handshake, even if the queue's
        // tvalid drops meanwhile.
        if (frame_end) begin
          state_d = ST_GAP;
          en_d    = 1'b0;
          if (!strict_q) begin
            if (credit_q[sel_q] > WEIGHT_WIDTH'(1)) begin
              // Credit left: stay on this queue for its next frame.
              credit_d[sel_q] = credit_q[sel_q] - WEIGHT_WIDTH'(1);
              ptr_d           = sel_q;
            end else begin
              credit_d[sel_q] = '0;
              ptr_d = (sel_q == SEL_WIDTH'(N_FIFO - 1)) ? '0
                                                       : sel_q + SEL_WIDTH'(1);
            end
          end
        end
      end

      // One idle cycle with en low so the mux closes the frame.
      ST_GAP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      en_q     <= 1'b0;
      strict_q <= 1'b0;
      ptr_q    <= '0;
      round_q  <= '0;
      for (int i = 0; i < N_FIFO; i++) begin
        credit_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      strict_q <= strict_d;
      ptr_q    <= ptr_d;
      round_q  <= round_d;
      for (int i = 0; i < N_FIFO; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign sel         = sel_q;
  assign en          = en_q;
  assign round_count = round_q;

endmodule

// File: tb/tb_fifo_wrr_sched.sv
// ---------------------------------------------------------------------------
// tb_fifo_wrr_sched
//
// Self-checking bench for fifo_wrr_sched. A table of scheduling scenarios
// gives the expected grant order and round_count per grant. The expected
// grants are queued when a scenario is loaded and popped as grants appear.
// Hand-written sequences cover reset, mode change, stalled multi-beat frames
// and reset in mid-frame.
// ---------------------------------------------------------------------------
module tb_fifo_wrr_sched;

  localparam int N  = 3;
  localparam int SW = 2;
  localparam int WW = 8;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  s_axis_tvalid = '0;
  logic          m_axis_tvalid = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast = 1'b0;
  logic          cfg_strict = 1'b1;
  logic [N*WW-1:0] cfg_weight = '0;
  logic [SW-1:0] sel;
  logic          en;
  logic [RW-1:0] round_count;

  fifo_wrr_sched #(
    .N_FIFO(N), .SEL_WIDTH(SW), .WEIGHT_WIDTH(WW), .ROUND_CNT_WIDTH(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .cfg_strict(cfg_strict), .cfg_weight(cfg_weight),
    .sel(sel), .en(en), .round_count(round_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected grants
  typedef struct packed {
    logic [SW-1:0] sel;
    logic [RW-1:0] rc;
  } grant_t;
  grant_t exp_q[$];
  int     last_grant_cyc = -1;

  task automatic push_grant(input logic [SW-1:0] s, input logic [RW-1:0] rc);
    grant_t g;
    g.sel = s;
    g.rc  = rc;
    exp_q.push_back(g);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (en === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Compare the grant now on the outputs against the scoreboard head.
  task automatic take_grant(input int exp_gap);
    grant_t g;
    check("scoreboard_nonempty", exp_q.size(), (exp_q.size() == 0) ? 1 : exp_q.size());
    if (exp_q.size() == 0) return;
    g = exp_q.pop_front();
    check("grant_sel", sel, g.sel);
    check("grant_round_count", round_count, g.rc);
    if (exp_gap > 0 && last_grant_cyc >= 0)
      check("grant_spacing", cyc - last_grant_cyc, exp_gap);
    last_grant_cyc = cyc;
    $display("grant sel=%0d round_count=%0d cycle=%0d", sel, round_count, cyc);
  endtask

  // Wait for a grant, check it, then send a frame of 'beats' beats.
  task automatic serve_frame(input int beats, input int exp_gap);
    bit ok;
    logic [SW-1:0] gsel;
    wait_grant(ok);
    check("grant_seen", ok, 1'b1);
    if (!ok) return;
    take_grant(exp_gap);
    gsel = sel;
    for (int b = 0; b < beats; b++) begin
      m_axis_tvalid = 1'b1;
      m_axis_tready = 1'b1;
      m_axis_tlast  = (b == beats - 1);
      @(negedge clk);
      if (b < beats - 1) begin
        check("en_in_frame", en, 1'b1);
        check("sel_in_frame", sel, gsel);
      end
    end
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    m_axis_tlast  = 1'b0;
    check("gap_en", en, 1'b0);
  endtask

  task automatic reset_assert();
    @(negedge clk);
    rst_n         = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tvalid = '0;
    @(negedge clk);
  endtask

  // Scenario table
  typedef struct packed {
    logic            strict;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    valid;
    logic [3:0]      nfr;
    logic [15:0]     seq;   // grant k at [2k +: 2]
    logic [31:0]     rcs;   // round_count after grant k at [4k +: 4]
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] seq;
    logic [31:0] rcs;
    bit ok;

    vecs[0] = '{1'b1, 24'h010203, 3'b111, 4'd4, 16'h0000, 32'h0000_0000};
    vecs[1] = '{1'b1, 24'h010203, 3'b110, 4'd3, 16'h0015, 32'h0000_0000};
    vecs[2] = '{1'b1, 24'h000000, 3'b100, 4'd2, 16'h000A, 32'h0000_0000};
    vecs[3] = '{1'b0, 24'h010102, 3'b111, 4'd8, 16'h9090, 32'h2222_1111};
    vecs[4] = '{1'b0, 24'h000300, 3'b101, 4'd4, 16'h0088, 32'h0000_2211};
    vecs[5] = '{1'b0, 24'h010101, 3'b010, 4'd3, 16'h0015, 32'h0000_0321};
    vecs[6] = '{1'b0, 24'h020103, 3'b111, 4'd7, 16'h0A40, 32'h0211_1111};

    // Reset held with all queues requesting
    cfg_strict    = 1'b1;
    s_axis_tvalid = 3'b111;
    repeat (3) @(negedge clk);
    check("reset_en", en, 1'b0);
    check("reset_sel", sel, '0);
    check("reset_round_count", round_count, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_en", en, 1'b1);
    check("release_sel", sel, '0);

    // Strict: q0 wins while backlogged. After q0 drops, q1 is next.
    last_grant_cyc = -1;
    push_grant(2'd0, 16'd0);
    serve_frame(1, 0);
    push_grant(2'd0, 16'd0);
    serve_frame(1, 3);
    s_axis_tvalid = 3'b110;
    push_grant(2'd1, 16'd0);
    serve_frame(1, 3);

    // Table-driven scenarios, each from a fresh reset
    for (int v = 0; v < 7; v++) begin
      reset_assert();
      cfg_strict    = vecs[v].strict;
      cfg_weight    = vecs[v].weight;
      s_axis_tvalid = vecs[v].valid;
      seq = vecs[v].seq;
      rcs = vecs[v].rcs;
      for (int k = 0; k < int'(vecs[v].nfr); k++)
        push_grant(seq[2*k +: 2], RW'(rcs[4*k +: 4]));
      last_grant_cyc = -1;
      rst_n = 1'b1;
      for (int k = 0; k < int'(vecs[v].nfr); k++)
        serve_frame(1, 3);
      check("scenario_drained", exp_q.size(), 0);
    end

    // Stalled 4-beat frame on q1. q0 arrives during the frame.
    reset_assert();
    cfg_strict    = 1'b0;
    cfg_weight    = 24'h010101;
    s_axis_tvalid = 3'b010;
    rst_n = 1'b1;
    push_grant(2'd1, 16'd1);
    last_grant_cyc = -1;
    wait_grant(ok);
    check("stall_grant_seen", ok, 1'b1);
    take_grant(0);
    begin
      logic [2:0] steps [7];
      logic [2:0] st;
      // {tvalid, tready, tlast}: two beats, two stall cycles, a beat,
      // a bubble with tlast high but tvalid low, then the last beat
      steps[0] = 3'b110; steps[1] = 3'b110; steps[2] = 3'b100;
      steps[3] = 3'b100; steps[4] = 3'b110; steps[5] = 3'b011;
      steps[6] = 3'b111;
      for (int s = 0; s < 7; s++) begin
        st = steps[s];
        m_axis_tvalid = st[2];
        m_axis_tready = st[1];
        m_axis_tlast  = st[0];
        if (s == 0) s_axis_tvalid = 3'b011;
        @(negedge clk);
        if (s < 6) begin
          check("stall_en", en, 1'b1);
          check("stall_sel", sel, 2'd1);
        end
      end
    end
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    m_axis_tlast  = 1'b0;
    check("stall_gap_en", en, 1'b0);
    check("stall_gap_sel", sel, 2'd1);
    @(negedge clk);
    check("stall_idle_en", en, 1'b0);
    @(negedge clk);
    check("stall_regrant_en", en, 1'b1);
    push_grant(2'd0, 16'd1);
    serve_frame(1, 0);

    // Reset pulled during beat 2 of a frame
    reset_assert();
    cfg_strict    = 1'b0;
    cfg_weight    = 24'h010102;
    s_axis_tvalid = 3'b111;
    rst_n = 1'b1;
    last_grant_cyc = -1;
    push_grant(2'd0, 16'd1);
    serve_frame(1, 0);
    push_grant(2'd0, 16'd1);
    wait_grant(ok);
    check("midrst_grant_seen", ok, 1'b1);
    take_grant(3);
    m_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    m_axis_tlast  = 1'b0;
    @(negedge clk);
    check("midrst_beat1_en", en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async_en", en, 1'b0);
    check("midrst_async_round_count", round_count, '0);
    @(negedge clk);
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    rst_n = 1'b1;
    last_grant_cyc = -1;
    push_grant(2'd0, 16'd1);
    serve_frame(1, 0);
    push_grant(2'd0, 16'd1);
    serve_frame(1, 3);
    push_grant(2'd1, 16'd1);
    serve_frame(1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_wrr_sched.md
# fifo_wrr_sched

Frame-level scheduler that drives the `select`/`enable` inputs of the `axis_mux` draining the per-priority ingress FIFOs onto the single TX stream. It watches FIFO output `tvalid` and the mux output handshake, and grants one whole frame at a time. Two selection modes are supported: strict priority (index 0 highest) or weighted round-robin with per-queue frame credits. A grant never changes inside a frame.

## Interface
Parameters:
- `N_FIFO`, 3, number of queues / mux inputs
- `SEL_WIDTH`, `$clog2(N_FIFO)`, width of select
- `WEIGHT_WIDTH`, 8, width of each per-queue weight (frames per round)
- `ROUND_CNT_WIDTH`, 16, width of the round counter

Ports:
- `clk`  in  1  clock; all logic is rising-edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `s_axis_tvalid`  in  N_FIFO  FIFO output tvalid per queue (mux inputs)
- `m_axis_tvalid`  in  1  mux output tvalid
- `m_axis_tready`  in  1  mux output tready
- `m_axis_tlast`  in  1  mux output tlast
- `cfg_strict`  in  1  1 = strict priority, 0 = WRR
- `cfg_weight`  in  N_FIFO*WEIGHT_WIDTH  per-queue weight; queue i at `[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]`
- `sel`  out  SEL_WIDTH  mux select, registered
- `en`  out  1  mux enable, registered
- `round_count`  out  ROUND_CNT_WIDTH  number of WRR credit reloads, wraps

## Operation
- State machine states:
  - IDLE: `en`=0. If any `s_axis_tvalid` bit is set, choose queue q, register `sel`=q, go to ACTIVE. Otherwise stay in IDLE.
  - ACTIVE: `en`=1, `sel` held. When `m_axis_tvalid & m_axis_tready & m_axis_tlast`, go to GAP and update credits and pointer.
  - GAP: `en`=0 for exactly one cycle so the mux closes the frame, then go to IDLE.
- Strict mode: q is the lowest index with tvalid set. Credits, pointer and `round_count` are frozen.
- WRR mode:
  - Per-queue credit register `credit[i]`; round-robin pointer `ptr`.
  - A queue is eligible when its tvalid is set and `credit[i]`>0.
  - If no valid queue is eligible, reload all credits from `cfg_weight` in the same IDLE cycle and use the reloaded values for this decision. Increment `round_count` on each reload.
  - A weight of 0 loads as 1.
  - q is the first eligible queue searching `ptr, ptr+1, …, N_FIFO-1, 0, …` (modulo N_FIFO).
  - On frame end: `credit[q]` decrements. If it becomes 0, `ptr` = (q+1) mod N_FIFO; otherwise `ptr` = q, so the same queue is served again.
- `cfg_weight` changes take effect only at the next reload. `cfg_strict` is sampled in IDLE only.
- If the granted queue's tvalid drops during ACTIVE, the grant is held until its tlast handshake. There is no timeout.
- Width rules: credits are WEIGHT_WIDTH bits, saturating at 0. `round_count` wraps modulo 2^ROUND_CNT_WIDTH.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `en`=0, `sel`=0, `round_count`=0
  - state IDLE, `ptr`=0
  - all credits 0, so the first WRR decision forces a reload
- Grant latency: a tvalid seen in an IDLE cycle gives `sel` and `en`=1 on the next edge.
- Per-frame overhead: 2 cycles (decision cycle plus GAP). A 1-beat frame is served every 3 cycles when backlogged.
- `sel` is stable from the edge that raises `en` until the edge after `en` falls.
- Last-beat handshake in cycle N: `en`=0 at N+1 (GAP), earliest next `en`=1 at N+3.
- Simultaneous valid arrivals in one IDLE cycle are resolved by the mode rules above. Arrivals during ACTIVE or GAP are considered at the next IDLE.
- Reset mid-frame: `en` drops asynchronously. After release the block restarts in IDLE with reset values. No recovery of the partial frame is attempted.

## Test plan
- Reset: hold `rst_n`=0 with all tvalid=1 → `en`=0, `sel`=0, `round_count`=0. Release → `en`=1, `sel`=0 (strict) one edge later.
- Strict priority: `cfg_strict`=1, all queues backlogged, 1-beat frames → `sel`=0 for every grant. Deassert q0 tvalid → next grant `sel`=1, `round_count` unchanged.
- WRR weights {2,1,1}, all backlogged, 1-beat frames → grant order 0,0,1,2,0,0,1,2. `round_count` increments at the 1st and 5th grants (value 2 after 8 grants). Frame spacing is 3 cycles.
- WRR weights {0,3,0} with only q0 and q2 valid → order 0,2,0,2. The zero weights behave as 1.
- 4-beat frame on q1 with `m_axis_tready` low for 2 cycles mid-frame, while q0 becomes valid → `sel`=1 and `en`=1 throughout, `en`=0 exactly one cycle after the tlast handshake, then q0 is granted.
- Pull `rst_n` low during beat 2 of a frame → `en`=0 in the same cycle. After release, credits reload on the first WRR decision and `round_count`=1.
